id_decode_stage: RTL and testbench

//  RV32I decode stage and ID/EX pipeline register; the producer side of the execute ALU interface.

---
 rtl/id_decode_stage.sv | 166 ++++++++++++++++
 tb/tb_id_decode_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decoder plus ID/EX register; ports: clk/rst, fetch handshake (if_valid, if_instr, if_pc, id_ready), flush, EX handshake (ex_ready, id_valid) and decoded fields/flags
module id_decode_stage #(
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [3:0]  alu_op,
  output logic [1:0]  src_a_sel,
  output logic [1:0]  src_b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4, XOR = 4'd5,
                         SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9, PASSB = 4'd15;
  logic [31:0] i;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  base, d_op;
  logic [1:0]  d_a, d_b;
  logic [31:0] d_imm;
  logic        d_rw, d_mr, d_mw, d_br, d_jp, d_ill, cap;
  assign i     = if_instr;
  assign opc   = i[6:0];
  assign f3    = i[14:12];
  assign f7    = i[31:25];
  assign imm_i = {{20{i[31]}}, i[31:20]};
  assign imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
  assign imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u = {i[31:12], 12'b0};
  assign imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  assign base = f3 == 3'd0 ? ADD : f3 == 3'd1 ? SLL : f3 == 3'd2 ? SLT : f3 == 3'd3 ? SLTU :
                f3 == 3'd4 ? XOR : f3 == 3'd5 ? SRL : f3 == 3'd6 ? OR : AND;
  always_comb begin
    d_op = ADD;
    d_a = 2'd0;
    d_b = 2'd0;
    d_imm = '0;
    d_rw = 1'b0;
    d_mr = 1'b0;
    d_mw = 1'b0;
    d_br = 1'b0;
    d_jp = 1'b0;
    d_ill = 1'b0;
    case (opc)
      7'b0110011: begin
        d_ill = !(f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        d_op = f7[5] ? (f3 == 3'd0 ? SUB : SRA) : base;
        d_rw = 1'b1;
      end
      7'b0010011: begin
        d_ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'h20);
        d_op = (f3 == 3'd5 && f7[5]) ? SRA : base;
        d_b = 2'd1;
        // shifts carry only the shamt; the upper field is an opcode extension
        d_imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, i[24:20]} : imm_i;
        d_rw = 1'b1;
      end
      7'b0110111: begin
        d_op = PASSB;
        d_b = 2'd1;
        d_imm = imm_u;
        d_rw = 1'b1;
      end
      7'b0010111: begin
        d_a = 2'd1;
        d_b = 2'd1;
        d_imm = imm_u;
        d_rw = 1'b1;
      end
      7'b0000011: begin
        d_b = 2'd1;
        d_imm = imm_i;
        d_mr = 1'b1;
        d_rw = 1'b1;
      end
      7'b0100011: begin
        d_b = 2'd1;
        d_imm = imm_s;
        d_mw = 1'b1;
      end
      7'b1100011: begin
        d_ill = f3[2:1] == 2'b01;
        d_op = !f3[2] ? SUB : f3[1] ? SLTU : SLT;
        d_imm = imm_b;
        d_br = 1'b1;
      end
      7'b1101111: begin
        d_a = 2'd1;
        d_b = 2'd2;
        d_imm = imm_j;
        d_jp = 1'b1;
        d_rw = 1'b1;
      end
      7'b1100111: begin
        d_ill = f3 != 3'd0;
        d_a = 2'd1;
        d_b = 2'd2;
        d_imm = imm_i;
        d_jp = 1'b1;
        d_rw = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end
  assign id_ready = !id_valid || ex_ready;
  assign cap = if_valid && id_ready && !flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc <= '0;
      alu_op <= ADD;
      src_a_sel <= '0;
      src_b_sel <= '0;
      imm <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      funct3 <= '0;
      reg_write <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      is_branch <= 1'b0;
      is_jump <= 1'b0;
      illegal <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (cap) begin
      id_valid <= !d_ill || ILLEGAL_AS_NOP;
      id_pc <= if_pc;
      alu_op <= d_ill ? ADD : d_op;
      src_a_sel <= d_a;
      src_b_sel <= d_b;
      imm <= d_imm;
      rs1 <= i[19:15];
      rs2 <= i[24:20];
      rd <= i[11:7];
      funct3 <= f3;
      reg_write <= d_rw && !d_ill && i[11:7] != 5'd0;
      mem_read <= d_mr && !d_ill;
      mem_write <= d_mw && !d_ill;
      is_branch <= d_br && !d_ill;
      is_jump <= d_jp && !d_ill;
      illegal <= d_ill;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed checks of decode, handshake, stall, flush, reset and illegal handling
module tb_id_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic        id_ready, id_valid, reg_write, mem_read, mem_write, is_branch, is_jump, illegal;
  logic [31:0] id_pc, imm;
  logic [3:0]  alu_op;
  logic [1:0]  src_a_sel, src_b_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  int total = 0, bad = 0;
  id_decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
    .id_pc(id_pc), .alu_op(alu_op), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
    .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .is_branch(is_branch), .is_jump(is_jump),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc = pc;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_alu", 32'(alu_op), 0);
    chk("rst_imm", imm, 0);
    chk("rst_rw", 32'(reg_write), 0);
    rst = 1'b0;
    #0;
    chk("rst_ready", 32'(id_ready), 1);
    send(32'h002081B3, 32'h100);
    chk("add_valid", 32'(id_valid), 1);
    chk("add_alu", 32'(alu_op), 0);
    chk("add_rs1", 32'(rs1), 1);
    chk("add_rs2", 32'(rs2), 2);
    chk("add_rd", 32'(rd), 3);
    chk("add_asel", 32'(src_a_sel), 0);
    chk("add_bsel", 32'(src_b_sel), 0);
    chk("add_rw", 32'(reg_write), 1);
    chk("add_pc", id_pc, 32'h100);
    send(32'h402081B3, 32'h104);
    chk("sub_alu", 32'(alu_op), 1);
    send(32'h40315093, 32'h108);
    chk("srai_alu", 32'(alu_op), 7);
    chk("srai_imm", imm, 3);
    chk("srai_bsel", 32'(src_b_sel), 1);
    chk("srai_rd", 32'(rd), 1);
    send(32'h123452B7, 32'h10C);
    chk("lui_alu", 32'(alu_op), 15);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rd", 32'(rd), 5);
    chk("lui_rw", 32'(reg_write), 1);
    send(32'h12345037, 32'h110);
    chk("lui0_rw", 32'(reg_write), 0);
    chk("lui0_valid", 32'(id_valid), 1);
    send(32'hFFC3A303, 32'h114);
    chk("lw_mr", 32'(mem_read), 1);
    chk("lw_imm", imm, 32'hFFFFFFFC);
    chk("lw_rs1", 32'(rs1), 7);
    chk("lw_f3", 32'(funct3), 2);
    send(32'h0020A423, 32'h118);
    chk("sw_mw", 32'(mem_write), 1);
    chk("sw_rw", 32'(reg_write), 0);
    chk("sw_imm", imm, 8);
    send(32'hFE208CE3, 32'h11C);
    chk("beq_br", 32'(is_branch), 1);
    chk("beq_alu", 32'(alu_op), 1);
    chk("beq_imm", imm, 32'hFFFFFFF8);
    chk("beq_rw", 32'(reg_write), 0);
    send(32'h010000EF, 32'h120);
    chk("jal_jp", 32'(is_jump), 1);
    chk("jal_imm", imm, 32'h10);
    chk("jal_asel", 32'(src_a_sel), 1);
    chk("jal_bsel", 32'(src_b_sel), 2);
    chk("jal_rw", 32'(reg_write), 1);
    send(32'h00001217, 32'h124);
    chk("auipc_asel", 32'(src_a_sel), 1);
    chk("auipc_imm", imm, 32'h1000);
    chk("auipc_alu", 32'(alu_op), 0);
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(32'h002081B3, 32'h200);
      chk("stall_ready", 32'(id_ready), 0);
      chk("stall_valid", 32'(id_valid), 1);
      chk("stall_imm", imm, 32'h1000);
      chk("stall_pc", id_pc, 32'h124);
    end
    ex_ready = 1'b1;
    #0;
    chk("unstall_ready", 32'(id_ready), 1);
    tick();
    chk("unstall_rd", 32'(rd), 3);
    chk("unstall_pc", id_pc, 32'h200);
    flush = 1'b1;
    send(32'h123452B7, 32'h204);
    flush = 1'b0;
    chk("flush_valid", 32'(id_valid), 0);
    chk("flush_rd", 32'(rd), 3);
    send(32'h002081B3, 32'h208);
    ex_ready = 1'b0;
    send(32'h402081B3, 32'h20C);
    chk("prerst_valid", 32'(id_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_ready = 1'b1;
    chk("midrst_valid", 32'(id_valid), 0);
    send(32'h0000007F, 32'h300);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_valid", 32'(id_valid), 0);
    chk("ill_rw", 32'(reg_write), 0);
    chk("ill_mem", {mem_read, mem_write}, 0);
    send(32'h202081B3, 32'h304);
    chk("ill_f7", 32'(illegal), 1);
    send(32'h0020A063, 32'h308);
    chk("ill_br", 32'(illegal), 1);
    chk("ill_br_flag", 32'(is_branch), 0);
    send(32'h002081B3, 32'h30C);
    chk("legal_again", 32'(illegal), 0);
    if_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(id_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
